// File: rtl/pb_io_pkg.sv
// pb_io_pkg
// Shared constants and helpers for the PicoBlaze I/O register bank.
// Holds the fixed addresses of the interrupt and identification registers,
// the port-count ceiling that keeps the port windows clear of 0xF0..0xFF,
// and a small decoder that classifies a port_id for the read multiplexer.
package pb_io_pkg;

    localparam logic [7:0] ADDR_IRQ_PEND = 8'hF0;
    localparam logic [7:0] ADDR_IRQ_MASK = 8'hF1;
    localparam logic [7:0] ADDR_ID_NIN   = 8'hF2;
    localparam logic [7:0] ADDR_ID_NOUT  = 8'hF3;

    // Port windows start at 0x00 and must never reach the register block at 0xF0.
    localparam int MAX_PORTS = 240;

    typedef enum logic [2:0] {
        SEL_PORT = 3'd0,
        SEL_PEND = 3'd1,
        SEL_MASK = 3'd2,
        SEL_NIN  = 3'd3,
        SEL_NOUT = 3'd4
    } rd_sel_e;

    // Anything that is not one of the fixed registers falls through to the
    // input-port window; an unmatched port there reads as zero.
    function automatic rd_sel_e special_sel(input logic [7:0] addr);
        case (addr)
            ADDR_IRQ_PEND: return SEL_PEND;
            ADDR_IRQ_MASK: return SEL_MASK;
            ADDR_ID_NIN:   return SEL_NIN;
            ADDR_ID_NOUT:  return SEL_NOUT;
            default:       return SEL_PORT;
        endcase
    endfunction

endpackage

// File: rtl/pb_irq_ctrl.sv
// pb_irq_ctrl
// Interrupt controller for the PicoBlaze register bank.
// Detects rising edges on the synchronous interrupt sources, latches them in
// IRQ_PEND (write-1-to-clear, set wins over clear), holds IRQ_MASK, registers
// ACT = |(PEND & MASK) and drives the interrupt flip-flop, which sets on a
// 0->1 of ACT and clears on interrupt_ack.
// Ports:
//   sysclk, sysreset      clock, synchronous active-low reset
//   irq_src[N_IRQ]        interrupt sources
//   pend_w1c, mask_wr     decoded write strobes for IRQ_PEND / IRQ_MASK
//   wr_bits[N_IRQ]        write data (only the implemented bits)
//   interrupt_ack         acknowledge from the processor
//   irq_pend, irq_mask    DW-wide read views, unimplemented bits zero
//   interrupt             interrupt request
module pb_irq_ctrl
    import pb_io_pkg::*;
#(
    parameter int DW    = 8,
    parameter int N_IRQ = 4
) (
    input  logic             sysclk,
    input  logic             sysreset,
    input  logic [N_IRQ-1:0] irq_src,
    input  logic             pend_w1c,
    input  logic             mask_wr,
    input  logic [N_IRQ-1:0] wr_bits,
    input  logic             interrupt_ack,
    output logic [DW-1:0]    irq_pend,
    output logic [DW-1:0]    irq_mask,
    output logic             interrupt
);

    generate
        if (N_IRQ < 1 || N_IRQ > DW) begin : g_bad_nirq
            $error("pb_irq_ctrl: N_IRQ must be in 1..DW");
        end
    endgenerate

    logic [N_IRQ-1:0] irq_src_p1;
    logic [N_IRQ-1:0] pend_r;
    logic [N_IRQ-1:0] mask_r;
    logic [N_IRQ-1:0] rise_p0;
    logic [N_IRQ-1:0] pend_nxt;
    logic             act_p1;
    logic             act_p2;
    logic             irq_r;

    // Edge detect against last cycle's sample; a clear and a fresh edge on the
    // same bit in one cycle leaves the bit set.
    always_comb begin
        rise_p0  = irq_src & ~irq_src_p1;
        pend_nxt = (pend_r & ~(pend_w1c ? wr_bits : '0)) | rise_p0;
    end

    // ---- stage p1: pend/mask state, ACT; stage p2: ACT history, interrupt ----
    always_ff @(posedge sysclk) begin
        if (!sysreset) begin
            irq_src_p1 <= '0;
            pend_r     <= '0;
            mask_r     <= '0;
            act_p1     <= 1'b0;
            act_p2     <= 1'b0;
            irq_r      <= 1'b0;
        end else begin
            irq_src_p1 <= irq_src;
            pend_r     <= pend_nxt;
            if (mask_wr) begin
                mask_r <= wr_bits;
            end
            act_p1 <= |(pend_r & mask_r);
            act_p2 <= act_p1;
            // Ack beats a simultaneous rise; otherwise only a fresh rise of
            // ACT re-arms, so a level that stays high after ack is ignored.
            if (interrupt_ack) begin
                irq_r <= 1'b0;
            end else if (act_p1 && !act_p2) begin
                irq_r <= 1'b1;
            end
        end
    end

    assign irq_pend  = DW'(pend_r);
    assign irq_mask  = DW'(mask_r);
    assign interrupt = irq_r;

endmodule

// File: rtl/pb_io_regbank.sv
// pb_io_regbank
// PicoBlaze (KCPSM6) I/O register bank.
// Read side: registered multiplexer over N_IN input ports plus the interrupt
// and identification registers, updated every cycle from port_id, with a
// one-cycle rd_pulse per input port read (FIFO pop).
// Write side: N_OUT output registers, each with a one-cycle wr_pulse.
// Interrupt logic lives in pb_irq_ctrl.
// Ports:
//   sysclk, sysreset             clock, synchronous active-low reset
//   port_id, write_strobe,
//   read_strobe, io_data_in      PicoBlaze I/O bus
//   io_data_out                  registered read data
//   in_data  [N_IN*DW]           input port k at [k*DW +: DW]
//   out_data [N_OUT*DW]          output register k at [k*DW +: DW]
//   rd_pulse [N_IN], wr_pulse [N_OUT]   per-port access pulses
//   irq_src, interrupt, interrupt_ack   interrupt sources and handshake
module pb_io_regbank
    import pb_io_pkg::*;
#(
    parameter int DW    = 8,
    parameter int N_IN  = 16,
    parameter int N_OUT = 16,
    parameter int N_IRQ = 4
) (
    input  logic                sysclk,
    input  logic                sysreset,
    input  logic [7:0]          port_id,
    input  logic                write_strobe,
    input  logic                read_strobe,
    input  logic [DW-1:0]       io_data_in,
    output logic [DW-1:0]       io_data_out,
    input  logic [N_IN*DW-1:0]  in_data,
    output logic [N_OUT*DW-1:0] out_data,
    output logic [N_IN-1:0]     rd_pulse,
    output logic [N_OUT-1:0]    wr_pulse,
    input  logic [N_IRQ-1:0]    irq_src,
    output logic                interrupt,
    input  logic                interrupt_ack
);

    generate
        if (N_IN < 1 || N_IN > MAX_PORTS) begin : g_bad_nin
            $error("pb_io_regbank: N_IN must be in 1..240");
        end
        if (N_OUT < 1 || N_OUT > MAX_PORTS) begin : g_bad_nout
            $error("pb_io_regbank: N_OUT must be in 1..240");
        end
        if (N_IRQ < 1 || N_IRQ > DW) begin : g_bad_nirq
            $error("pb_io_regbank: N_IRQ must be in 1..DW");
        end
    endgenerate

    logic [DW-1:0]       irq_pend;
    logic [DW-1:0]       irq_mask;
    logic                pend_w1c;
    logic                mask_wr;
    rd_sel_e             rd_sel_p0;
    logic [DW-1:0]       rd_in_p0;
    logic [DW-1:0]       rd_word_p0;
    logic [N_IN-1:0]     rd_hit_p0;
    logic [N_OUT-1:0]    wr_hit_p0;
    logic [N_OUT*DW-1:0] out_r;

    assign pend_w1c = write_strobe && (port_id == ADDR_IRQ_PEND);
    assign mask_wr  = write_strobe && (port_id == ADDR_IRQ_MASK);

    pb_irq_ctrl #(
        .DW    (DW),
        .N_IRQ (N_IRQ)
    ) u_irq_ctrl (
        .sysclk        (sysclk),
        .sysreset      (sysreset),
        .irq_src       (irq_src),
        .pend_w1c      (pend_w1c),
        .mask_wr       (mask_wr),
        .wr_bits       (io_data_in[N_IRQ-1:0]),
        .interrupt_ack (interrupt_ack),
        .irq_pend      (irq_pend),
        .irq_mask      (irq_mask),
        .interrupt     (interrupt)
    );

    // Every port is matched with a full 8-bit compare so aliases never occur;
    // the port windows stay below 0xF0, so they cannot collide with the
    // fixed registers.
    always_comb begin
        rd_in_p0  = '0;
        rd_hit_p0 = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (port_id == 8'(k)) begin
                rd_in_p0     = in_data[k*DW +: DW];
                rd_hit_p0[k] = 1'b1;
            end
        end
    end

    always_comb begin
        wr_hit_p0 = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (port_id == 8'(k)) begin
                wr_hit_p0[k] = 1'b1;
            end
        end
    end

    always_comb begin
        rd_sel_p0  = special_sel(port_id);
        rd_word_p0 = rd_in_p0;
        case (rd_sel_p0)
            SEL_PEND: rd_word_p0 = irq_pend;
            SEL_MASK: rd_word_p0 = irq_mask;
            SEL_NIN:  rd_word_p0 = DW'(N_IN);
            SEL_NOUT: rd_word_p0 = DW'(N_OUT);
            default:  rd_word_p0 = rd_in_p0;
        endcase
    end

    // ---- stage p1: read data, access pulses, output registers ----
    // Reset has priority, so a strobe seen during reset is dropped and never
    // turns into a pulse afterwards.
    always_ff @(posedge sysclk) begin
        if (!sysreset) begin
            io_data_out <= '0;
            rd_pulse    <= '0;
            wr_pulse    <= '0;
            out_r       <= '0;
        end else begin
            io_data_out <= rd_word_p0;
            rd_pulse    <= read_strobe ? rd_hit_p0 : '0;
            wr_pulse    <= write_strobe ? wr_hit_p0 : '0;
            for (int k = 0; k < N_OUT; k++) begin
                if (write_strobe && wr_hit_p0[k]) begin
                    out_r[k*DW +: DW] <= io_data_in;
                end
            end
        end
    end

    assign out_data = out_r;

endmodule

// File: tb/tb_pb_io_regbank.sv
module tb_pb_io_regbank;

    localparam int DW    = 8;
    localparam int N_IN  = 16;
    localparam int N_OUT = 16;
    localparam int N_IRQ = 4;

    logic                sysclk = 1'b0;
    logic                sysreset;
    logic [7:0]          port_id;
    logic                write_strobe;
    logic                read_strobe;
    logic [DW-1:0]       io_data_in;
    logic [DW-1:0]       io_data_out;
    logic [N_IN*DW-1:0]  in_data;
    logic [N_OUT*DW-1:0] out_data;
    logic [N_IN-1:0]     rd_pulse;
    logic [N_OUT-1:0]    wr_pulse;
    logic [N_IRQ-1:0]    irq_src;
    logic                interrupt;
    logic                interrupt_ack;

    int n_chk  = 0;
    int n_fail = 0;

    pb_io_regbank #(.DW(DW), .N_IN(N_IN), .N_OUT(N_OUT), .N_IRQ(N_IRQ)) dut (
        .sysclk        (sysclk),
        .sysreset      (sysreset),
        .port_id       (port_id),
        .write_strobe  (write_strobe),
        .read_strobe   (read_strobe),
        .io_data_in    (io_data_in),
        .io_data_out   (io_data_out),
        .in_data       (in_data),
        .out_data      (out_data),
        .rd_pulse      (rd_pulse),
        .wr_pulse      (wr_pulse),
        .irq_src       (irq_src),
        .interrupt     (interrupt),
        .interrupt_ack (interrupt_ack)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        logic [7:0]  pid;
        logic        rd;
        logic [7:0]  exp_dout;
        logic [15:0] exp_rdp;
    } rd_vec_t;

    typedef struct {
        logic [7:0]  pid;
        logic [7:0]  din;
        logic [15:0] exp_wrp;
    } wr_vec_t;

    rd_vec_t rtab[10];
    wr_vec_t wtab[6];

    // Behavioural reference state
    logic [7:0]  m_out[N_OUT];
    logic [3:0]  m_pend, m_mask, m_src;
    logic        m_act, m_act_d, m_int;
    logic [7:0]  m_dout;
    logic [15:0] m_rd, m_wr;
    logic [7:0]  exp_out[N_OUT];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        write_strobe = 1'b1;
        port_id      = a;
        io_data_in   = d;
        tick();
        write_strobe = 1'b0;
    endtask

    function automatic logic [7:0] in_val(input int k);
        if (k == 5) return 8'h3C;
        return 8'(8'h81 + k * 13);
    endfunction

    function automatic logic [127:0] pack(input logic [7:0] a[N_OUT]);
        logic [127:0] v = '0;
        for (int k = 0; k < N_OUT; k++) v[k*8 +: 8] = a[k];
        return v;
    endfunction

    function automatic logic [7:0] model_read(input logic [7:0] a);
        if (a < N_IN) return in_data[a*8 +: 8];
        if (a == 8'hF0) return {4'h0, m_pend};
        if (a == 8'hF1) return {4'h0, m_mask};
        if (a == 8'hF2 || a == 8'hF3) return 8'd16;
        return 8'h00;
    endfunction

    // Advance the reference by one clock edge using the currently driven inputs.
    task automatic model_edge();
        logic [3:0] clr;
        logic       act_now;
        if (!sysreset) begin
            for (int k = 0; k < N_OUT; k++) m_out[k] = 8'h00;
            m_pend = 0; m_mask = 0; m_src = 0;
            m_act = 0; m_act_d = 0; m_int = 0;
            m_dout = 0; m_rd = 0; m_wr = 0;
        end else begin
            m_dout = model_read(port_id);
            m_rd = (read_strobe && port_id < N_IN) ? 16'(1 << port_id) : 16'h0;
            m_wr = (write_strobe && port_id < N_OUT) ? 16'(1 << port_id) : 16'h0;
            if (write_strobe && port_id < N_OUT) m_out[port_id[3:0]] = io_data_in;
            act_now = (m_pend & m_mask) != 0;
            if (interrupt_ack) m_int = 0;
            else if (m_act && !m_act_d) m_int = 1;
            m_act_d = m_act;
            m_act   = act_now;
            clr = (write_strobe && port_id == 8'hF0) ? io_data_in[3:0] : 4'h0;
            m_pend = (m_pend & ~clr) | (irq_src & ~m_src);
            if (write_strobe && port_id == 8'hF1) m_mask = io_data_in[3:0];
            m_src = irq_src;
        end
    endtask

    initial begin
        sysreset = 1'b0; port_id = 8'h00; write_strobe = 1'b0; read_strobe = 1'b0;
        io_data_in = 8'h00; irq_src = '0; interrupt_ack = 1'b0;
        for (int k = 0; k < N_IN; k++) in_data[k*8 +: 8] = in_val(k);

        // Reset state
        tick(); tick();
        chk("rst_dout", io_data_out, 0);
        chk("rst_out", out_data, 0);
        chk("rst_rdp", rd_pulse, 0);
        chk("rst_wrp", wr_pulse, 0);
        chk("rst_int", interrupt, 0);
        sysreset = 1'b1;
        tick();

        // Read map table
        rtab[0] = '{8'h00, 1'b1, in_val(0),  16'h0001};
        rtab[1] = '{8'h05, 1'b1, 8'h3C,      16'h0020};
        rtab[2] = '{8'h0F, 1'b0, in_val(15), 16'h0000};
        rtab[3] = '{8'h10, 1'b1, 8'h00,      16'h0000};
        rtab[4] = '{8'h80, 1'b0, 8'h00,      16'h0000};
        rtab[5] = '{8'hF2, 1'b0, 8'h10,      16'h0000};
        rtab[6] = '{8'hF3, 1'b1, 8'h10,      16'h0000};
        rtab[7] = '{8'hF0, 1'b0, 8'h00,      16'h0000};
        rtab[8] = '{8'hF1, 1'b0, 8'h00,      16'h0000};
        rtab[9] = '{8'hFF, 1'b1, 8'h00,      16'h0000};
        for (int i = 0; i < 10; i++) begin
            port_id = rtab[i].pid;
            read_strobe = rtab[i].rd;
            tick();
            chk($sformatf("rd_dout[%0d]", i), io_data_out, rtab[i].exp_dout);
            chk($sformatf("rd_pulse[%0d]", i), rd_pulse, rtab[i].exp_rdp);
            read_strobe = 1'b0;
            tick();
            chk($sformatf("rd_pulse_once[%0d]", i), rd_pulse, 0);
        end

        // Write map table
        wtab[0] = '{8'h03, 8'hA5, 16'h0008};
        wtab[1] = '{8'h00, 8'h5A, 16'h0001};
        wtab[2] = '{8'h0F, 8'hC3, 16'h8000};
        wtab[3] = '{8'h10, 8'h77, 16'h0000};
        wtab[4] = '{8'hF2, 8'h99, 16'h0000};
        wtab[5] = '{8'hEE, 8'h11, 16'h0000};
        for (int k = 0; k < N_OUT; k++) exp_out[k] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            do_write(wtab[i].pid, wtab[i].din);
            if (wtab[i].pid < N_OUT) exp_out[wtab[i].pid[3:0]] = wtab[i].din;
            chk($sformatf("wr_pulse[%0d]", i), wr_pulse, wtab[i].exp_wrp);
            chk($sformatf("wr_out[%0d]", i), out_data, pack(exp_out));
            tick();
            chk($sformatf("wr_pulse_once[%0d]", i), wr_pulse, 0);
            chk($sformatf("wr_hold[%0d]", i), out_data, pack(exp_out));
        end

        // Masked source, latency n+3, ack, no re-arm, W1C
        do_write(8'hF1, 8'h01);
        irq_src = 4'b0001;
        tick(); chk("irq_n1", interrupt, 0);
        irq_src = 4'b0000;
        tick(); chk("irq_n2", interrupt, 0);
        tick(); chk("irq_n3", interrupt, 1);
        interrupt_ack = 1'b1;
        tick(); chk("irq_ack", interrupt, 0);
        interrupt_ack = 1'b0;
        tick(); tick(); chk("irq_no_rearm", interrupt, 0);
        port_id = 8'hF0;
        tick(); chk("pend_read", io_data_out, 8'h01);
        do_write(8'hF0, 8'h01);
        tick(); chk("pend_w1c", io_data_out, 8'h00);

        // Pending while masked, then unmask
        do_write(8'hF1, 8'h00);
        irq_src = 4'b0100;
        tick(); tick();
        port_id = 8'hF0;
        tick(); chk("pend_masked", io_data_out, 8'h04);
        chk("int_masked", interrupt, 0);
        do_write(8'hF1, 8'h04);
        chk("unmask_m0", interrupt, 0);
        tick(); chk("unmask_m1", interrupt, 0);
        tick(); chk("unmask_m2", interrupt, 1);
        interrupt_ack = 1'b1;
        do_write(8'hF0, 8'h04);
        interrupt_ack = 1'b0;
        irq_src = 4'b0000;
        tick(); chk("unmask_ack", interrupt, 0);

        // Set beats simultaneous W1C
        irq_src = 4'b0010;
        do_write(8'hF0, 8'h02);
        port_id = 8'hF0;
        tick(); chk("set_wins", io_data_out, 8'h02);
        do_write(8'hF0, 8'h02);
        tick(); chk("w1c_no_set", io_data_out, 8'h00);
        irq_src = 4'b0000;
        tick();

        // Reset mid-transaction with state loaded
        for (int k = 0; k < N_OUT; k++) do_write(8'(k), 8'hFF);
        do_write(8'hF1, 8'h08);
        irq_src = 4'b1000;
        tick(); tick(); tick(); tick();
        chk("pre_rst_int", interrupt, 1);
        chk("pre_rst_out", out_data, {16{8'hFF}});
        sysreset = 1'b0; write_strobe = 1'b1; read_strobe = 1'b1;
        port_id = 8'h02; io_data_in = 8'h55;
        tick();
        chk("mid_rst_out", out_data, 0);
        chk("mid_rst_dout", io_data_out, 0);
        chk("mid_rst_rdp", rd_pulse, 0);
        chk("mid_rst_wrp", wr_pulse, 0);
        chk("mid_rst_int", interrupt, 0);
        sysreset = 1'b1; write_strobe = 1'b0; read_strobe = 1'b0; port_id = 8'hF0;
        tick();
        chk("post_rst_rdp", rd_pulse, 0);
        chk("post_rst_wrp", wr_pulse, 0);
        chk("post_rst_out", out_data, 0);
        chk("post_rst_dout", io_data_out, 0);
        tick(); chk("post_rst_pend", io_data_out, 8'h08);
        port_id = 8'hF1;
        tick(); chk("post_rst_mask", io_data_out, 8'h00);
        irq_src = 4'b0000;

        // Randomized run against the reference model
        sysreset = 1'b0;
        model_edge();
        tick();
        for (int c = 0; c < 1500; c++) begin
            int r;
            sysreset = ($urandom_range(0, 63) == 0) ? 1'b0 : 1'b1;
            r = $urandom_range(0, 9);
            if (r < 5)      port_id = 8'($urandom_range(0, 19));
            else if (r < 8) port_id = 8'($urandom_range(240, 243));
            else            port_id = 8'($urandom);
            write_strobe  = ($urandom_range(0, 2) == 0);
            read_strobe   = ($urandom_range(0, 2) == 0);
            io_data_in    = 8'($urandom);
            in_data       = {$urandom, $urandom, $urandom, $urandom};
            interrupt_ack = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) irq_src[$urandom_range(0, 3)] ^= 1'b1;
            model_edge();
            tick();
            chk("rnd_dout", io_data_out, m_dout);
            chk("rnd_out", out_data, pack(m_out));
            chk("rnd_rdp", rd_pulse, m_rd);
            chk("rnd_wrp", wr_pulse, m_wr);
            chk("rnd_int", interrupt, m_int);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pb_io_regbank.md
PB_IO_REGBANK -- requirements
Module: pb_io_regbank

Interface
REQ-001 Parameter DW, default 8: port data width; fixed at 8 for KCPSM6 use.
REQ-002 Parameter N_IN, default 16: number of input ports, range 1..240.
REQ-003 Parameter N_OUT, default 16: number of output registers, range 1..240.
REQ-004 Parameter N_IRQ, default 4: number of interrupt sources, range 1..DW.
REQ-005 Port sysclk in 1: the single clock; all logic on its rising edge.
REQ-006 Port sysreset in 1: reset, synchronous and active-low.
REQ-007 Port port_id in 8: I/O address from the PicoBlaze.
REQ-008 Port write_strobe in 1: qualifies a write of io_data_in to port_id.
REQ-009 Port read_strobe in 1: marks the cycle in which the PicoBlaze consumes read data.
REQ-010 Port io_data_in in DW: write data from the PicoBlaze.
REQ-011 Port io_data_out out DW: registered read data to the PicoBlaze.
REQ-012 Port in_data in N_IN*DW: input port k occupies bits [k*DW +: DW].
REQ-013 Port out_data out N_OUT*DW: output register k occupies bits [k*DW +: DW].
REQ-014 Port rd_pulse out N_IN: one-cycle pulse per input port read, used for FIFO pop.
REQ-015 Port wr_pulse out N_OUT: one-cycle pulse per output register written.
REQ-016 Port irq_src in N_IRQ: interrupt sources, synchronous to sysclk.
REQ-017 Port interrupt out 1: interrupt request to the PicoBlaze.
REQ-018 Port interrupt_ack in 1: interrupt acknowledge from the PicoBlaze.

Function
REQ-019 Address decode SHALL be full 8-bit binary compare; no one-hot or partial decode.
REQ-020 Read map: 0x00..N_IN-1 -> in_data[k]; 0xF0 -> IRQ_PEND; 0xF1 -> IRQ_MASK; 0xF2 -> N_IN; 0xF3 -> N_OUT; any other address -> 0x00 (never X).
REQ-021 io_data_out SHALL update every cycle from the current port_id, with one-cycle latency.
REQ-022 rd_pulse[k] SHALL assert for exactly one cycle, in the cycle after read_strobe=1 with port_id==k.
REQ-023 Write map (write_strobe=1 only): 0x00..N_OUT-1 -> out reg k; 0xF0 -> write-1-to-clear IRQ_PEND; 0xF1 -> IRQ_MASK; all other addresses ignored.
REQ-024 An out reg and its wr_pulse bit SHALL update at the same clock edge, one cycle after the strobe; registers not addressed SHALL hold.
REQ-025 IRQ_PEND[i] SHALL set at the edge where irq_src[i]=1 and the registered previous sample was 0, i.e. on rising edges only.
REQ-026 When a set event and a W1C of the same bit occur in the same cycle, the set SHALL win.
REQ-027 Define ACT = |(IRQ_PEND & IRQ_MASK), registered. interrupt SHALL set on the cycle after ACT goes 0->1.
REQ-028 interrupt SHALL clear when interrupt_ack=1, which has priority over a simultaneous set; interrupt SHALL otherwise hold.
REQ-029 After an ack, interrupt SHALL re-assert only on a new 0->1 of ACT, which requires software to clear pending bits or a newly unmasked bit.
REQ-030 Writing IRQ_MASK to unmask an already-pending bit while ACT=0 SHALL produce an ACT rise.
REQ-031 Latency: irq_src rises in cycle n -> IRQ_PEND set at edge n+1 -> ACT at n+2 -> interrupt at n+3.
REQ-032 Bits of IRQ_PEND and IRQ_MASK above N_IRQ SHALL read 0 and ignore writes.

Reset
REQ-033 While sysreset=0 at a clock edge, the following SHALL be cleared: all out regs, io_data_out, rd_pulse, wr_pulse, IRQ_PEND, IRQ_MASK, ACT, the irq_src edge history and interrupt.
REQ-034 The edge history SHALL reset to 0, so a source already high at reset release SHALL set pending on the first post-reset edge.
REQ-035 A reset asserted mid-transaction SHALL discard the strobe; no pulse SHALL be issued after reset.

Structure
REQ-036 Package pb_io_pkg SHALL hold the address constants ADDR_IRQ_PEND=0xF0, ADDR_IRQ_MASK=0xF1, ADDR_ID_NIN=0xF2 and ADDR_ID_NOUT=0xF3.
REQ-037 Sub-module pb_irq_ctrl SHALL contain the edge detect, IRQ_PEND, IRQ_MASK, ACT and the closed-loop interrupt flip-flop.
REQ-038 Elaboration SHALL fail if N_IN>240, N_OUT>240 or N_IRQ>DW.

Verification
REQ-039 Write 0xA5 to port 0x03 -> out_data[3]=0xA5 and wr_pulse=0x0008 for one cycle, one cycle after the strobe; other registers unchanged.
REQ-040 in_data[5]=0x3C, port_id=0x05 -> io_data_out=0x3C the next cycle; with read_strobe -> rd_pulse[5] pulses once; port_id=0x80 -> 0x00; port_id=0xF2 -> 0x10.
REQ-041 Mask=0x01, pulse irq_src[0] -> interrupt high at n+3; ack -> interrupt low the next cycle; read 0xF0 -> 0x01; write 0x01 to 0xF0 -> 0x00.
REQ-042 Mask=0x00, irq_src[2] rises -> pend=0x04 and no interrupt; then write mask 0x04 -> interrupt asserts.
REQ-043 irq_src[1] rises in the same cycle as a W1C of 0x02 -> pend bit 1 remains set.
REQ-044 Load out regs with 0xFF and set pend, then sysreset=0 for one edge -> all outputs 0x00, interrupt=0.
